// File: rtl/apb_counter_master.sv
// APB requester: turns single cmd/rsp requests into APB SETUP/ACCESS transfers.
// Define APB_MASTER_TIMEOUT_EN to abort transfers whose ACCESS phase stalls for TIMEOUT_CYCLES.
module apb_counter_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic              pwrite_reg, pwrite_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       rsp_timeout_reg, rsp_timeout_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      paddr_reg       <= '0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      paddr_reg       <= paddr_next;
      pwrite_reg      <= pwrite_next;
      pwdata_reg      <= pwdata_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg    <= wait_cnt_next;
      rsp_timeout_reg <= rsp_timeout_next;
`endif
    end
  end

  always_comb begin
    state_next       = state_reg;
    paddr_next       = paddr_reg;
    pwrite_next      = pwrite_reg;
    pwdata_next      = pwdata_reg;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_next    = '0;
    rsp_timeout_next = rsp_timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          pwdata_next = cmd_write ? cmd_wdata : '0;
          state_next  = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = pwrite_reg ? '0 : prdata;
          rsp_err_next   = pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_next = 1'b0;
        end else if (wait_cnt_reg == TIMEOUT_LAST) begin
          // This stalled cycle is the TIMEOUT_CYCLES-th one: abort.
          state_next       = IDLE;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = '0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready = (state_reg == IDLE);
  assign psel      = (state_reg != IDLE);
  assign penable   = (state_reg == ACCESS);
  assign pwrite    = pwrite_reg;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_reg;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/apb_counter_master.md
APB_COUNTER_MASTER -- requirements
Module: apb_counter_master

Interface
REQ-001 Parameter ADDR_W, 8, APB address width in bits.
REQ-002 Parameter DATA_W, 32, APB data width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles before abort (range 1..255).
REQ-004 Port clk  input  1  clock; all logic rising-edge.
REQ-005 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port cmd_valid  input  1  command request.
REQ-007 Port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 Port cmd_write  input  1  1 = write, 0 = read.
REQ-009 Port cmd_addr  input  ADDR_W  target address.
REQ-010 Port cmd_wdata  input  DATA_W  write data.
REQ-011 Port rsp_valid  output  1  single-cycle completion pulse.
REQ-012 Port rsp_rdata  output  DATA_W  read data; valid with rsp_valid.
REQ-013 Port rsp_err  output  1  transfer failed (slave error or timeout); valid with rsp_valid.
REQ-014 Port rsp_timeout  output  1  transfer aborted by timeout; valid with rsp_valid.
REQ-015 Ports psel, penable, pwrite  output  1 each  APB control.
REQ-016 Ports paddr  output  ADDR_W; pwdata  output  DATA_W  APB address/write data.
REQ-017 Ports prdata  input  DATA_W; pready, pslverr  input  1 each  APB completer response.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; cmd_ready SHALL be 1 only in IDLE, and cmd_valid outside IDLE SHALL be ignored.
REQ-019 IDLE with cmd_valid=1: latch cmd_write/addr/wdata; SETUP next cycle (psel=1, penable=0).
REQ-020 SETUP SHALL always go to ACCESS next cycle (psel=1, penable=1).
REQ-021 ACCESS: pready=0 -> stay; pready=1 -> capture prdata (reads) and pslverr, go IDLE.
REQ-022 paddr, pwrite, pwdata SHALL stay stable from SETUP until the cycle ACCESS completes; pwdata SHALL be 0 for reads.
REQ-023 rsp_valid SHALL pulse for exactly one cycle, the cycle after completion (first IDLE cycle); rsp_rdata = captured prdata for reads, 0 for writes; rsp_err = captured pslverr.
REQ-024 A new command SHALL be acceptable in the same cycle rsp_valid is high; minimum cmd-accept to cmd-accept spacing is 3 cycles.
REQ-025 psel, penable SHALL be 0 in IDLE; paddr SHALL hold its last value in IDLE.
REQ-026 No backpressure on the response; the consumer samples on rsp_valid.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, wait counter 0.
REQ-028 Reset during SETUP or ACCESS SHALL drop the in-flight command with no rsp_valid generated after release.
REQ-029 First command SHALL be acceptable in the first clock cycle after reset_n rises.

Configuration
REQ-030 Macro APB_MASTER_TIMEOUT_EN defined: an 8-bit counter counts consecutive ACCESS cycles with pready=0; when it reaches TIMEOUT_CYCLES, psel/penable drop next cycle, state goes IDLE, and rsp_valid pulses with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 Macro undefined: no counter is built, ACCESS waits indefinitely for pready, and rsp_timeout is tied 0.

Verification
REQ-032 Write addr 0x04 data 0x5, pready=1 at once -> psel at T+1, penable at T+2, rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
REQ-033 Read addr 0x08, pready low 3 ACCESS cycles then high with prdata=0x3 -> penable high 4 cycles, paddr stable, rsp_rdata=0x3, rsp_err=0.
REQ-034 Write with pslverr=1 on the completing cycle -> rsp_valid with rsp_err=1, rsp_timeout=0.
REQ-035 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; without the macro, no rsp_valid for 100 cycles.
REQ-036 reset_n low in the second ACCESS wait cycle -> all outputs 0 immediately; no rsp_valid after release; the next command completes normally.
REQ-037 Six back-to-back reads of the counter value register against a mod-6 counter completer -> rsp_rdata sequence stays within 0..5 and wraps 5->0; cmd_ready is low in SETUP and ACCESS.
